// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 add/sub (generic widths): 4-cycle latency, one op per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         op_sub,
    input  logic [2:0]   rounding_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [2:0]   exception
);
    localparam int FW = MAN_W + 4;
    localparam int EW = EXP_W + $clog2(FW) + 2;
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] EBIG = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !rst;

    // Stage registers
    logic v0, v1, v2, v3;
    logic [W-1:0] a0, b0;
    logic [2:0] rm0, rm1, rm2, rm3;
    logic spec1, spec2, spec3, sinv1, sinv2, sinv3;
    logic [W-1:0] sres1, sres2, sres3;
    logic sign1, sign2, sign3, sub1, zsign1, zsign2, zsign3;
    logic [EXP_W-1:0] exp1, exp2;
    logic [FW-1:0] fb1, fs1, mn3;
    logic [FW:0] sum2;
    logic zero3, uf3;
    logic [EW-1:0] exp3;

    // S1: unpack, classify, order by magnitude, align the smaller operand
    logic sa, sb;
    logic [EXP_W-1:0] ea, eb, e_big, e_sml, e_diff;
    logic [MAN_W-1:0] ma, mb, ma_f, mb_f;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge;
    logic [FW-1:0] f_big, f_sml, f_aln;
    logic [2*FW-1:0] f_wide;
    logic s1_spec, s1_sinv, s1_sign, s1_sub, s1_zsign;
    logic [W-1:0] s1_sres;
    int sh;

    assign {sa, ea, ma} = a0;
    assign {sb, eb, mb} = b0;
    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_snan = a_nan && !ma[MAN_W-1];
    assign b_snan = b_nan && !mb[MAN_W-1];
    assign a_inf  = (&ea) && !(|ma);
    assign b_inf  = (&eb) && !(|mb);

    always_comb begin
        ma_f = (ea == '0) ? '0 : ma;
        mb_f = (eb == '0) ? '0 : mb;
        a_ge = {ea, ma_f} >= {eb, mb_f};
        if (a_ge) begin
            e_big = ea; e_sml = eb; s1_sign = sa;
            f_big = {|ea, ma_f, 3'b000};
            f_sml = {|eb, mb_f, 3'b000};
        end else begin
            e_big = eb; e_sml = ea; s1_sign = sb;
            f_big = {|eb, mb_f, 3'b000};
            f_sml = {|ea, ma_f, 3'b000};
        end
        e_diff = e_big - e_sml;
        sh     = (int'(e_diff) > FW - 1) ? FW - 1 : int'(e_diff);
        // Lower half of the wide shift catches everything pushed past sticky
        f_wide = {f_sml, {FW{1'b0}}} >> sh;
        f_aln  = {f_wide[2*FW-1:FW+1], f_wide[FW] | (|f_wide[FW-1:0])};
        s1_sub   = sa ^ sb;
        s1_zsign = s1_sub ? (rm0 == RM_RDN) : sa;
        s1_spec  = a_nan || b_nan || a_inf || b_inf;
        s1_sinv  = 1'b0;
        if (a_nan || b_nan) begin
            s1_sres = QNAN;
            s1_sinv = a_snan || b_snan;
        end else if (a_inf && b_inf && s1_sub) begin
            s1_sres = QNAN;
            s1_sinv = 1'b1;
        end else if (a_inf) begin
            s1_sres = {sa, EMAX, {MAN_W{1'b0}}};
        end else begin
            s1_sres = {sb, EMAX, {MAN_W{1'b0}}};
        end
    end

    // S2: magnitude add or subtract; aligned smaller never exceeds larger
    logic [FW:0] s2_sum;
    always_comb begin
        if (sub1) s2_sum = {1'b0, fb1} - {1'b0, fs1};
        else      s2_sum = {1'b0, fb1} + {1'b0, fs1};
    end

    // S3: leading-zero count and normalise
    logic [EW-1:0] lz, s3_exp;
    logic [FW-1:0] s3_mn;
    logic s3_zero, s3_uf;
    always_comb begin
        lz = '0;
        for (int i = 0; i < FW; i++) begin
            if (sum2[i]) lz = EW'(FW - 1 - i);
        end
        s3_zero = !(|sum2);
        if (sum2[FW]) begin
            s3_mn  = {sum2[FW:2], sum2[1] | sum2[0]};
            s3_exp = {{(EW-EXP_W){1'b0}}, exp2} + {{(EW-1){1'b0}}, 1'b1};
        end else begin
            s3_mn  = sum2[FW-1:0] << lz;
            s3_exp = {{(EW-EXP_W){1'b0}}, exp2} - lz;
        end
        s3_uf = !s3_zero && (s3_exp[EW-1] || s3_exp == '0);
    end

    // S4: round, detect overflow, pack
    logic g, r, st, lsb, inx, inc, ovf, use_inf;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] man_r;
    logic [EW-1:0] er;
    logic [W-1:0] s4_res;
    logic [2:0] s4_exc;
    always_comb begin
        lsb = mn3[3];
        g   = mn3[2];
        r   = mn3[1];
        st  = mn3[0];
        inx = g | r | st;
        case (rm3)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign3 & inx;
            RM_RUP:  inc = !sign3 & inx;
            RM_RMM:  inc = g;
            default: inc = g & (r | st | lsb);
        endcase
        rnd   = {1'b0, mn3[FW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        er    = exp3 + {{(EW-1){1'b0}}, rnd[MAN_W+1]};
        man_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        ovf   = !er[EW-1] && (er >= {{(EW-EXP_W){1'b0}}, EMAX});
        case (rm3)
            RM_RTZ:  use_inf = 1'b0;
            RM_RUP:  use_inf = !sign3;
            RM_RDN:  use_inf = sign3;
            default: use_inf = 1'b1;
        endcase
        if (spec3) begin
            s4_res = sres3;
            s4_exc = {sinv3, 2'b00};
        end else if (zero3) begin
            s4_res = {zsign3, {(W-1){1'b0}}};
            s4_exc = 3'b000;
        end else if (uf3) begin
            s4_res = {sign3, {(W-1){1'b0}}};
            s4_exc = 3'b001;
        end else if (ovf) begin
            s4_res = use_inf ? {sign3, EMAX, {MAN_W{1'b0}}} : {sign3, EBIG, {MAN_W{1'b1}}};
            s4_exc = 3'b011;
        end else begin
            s4_res = {sign3, er[EXP_W-1:0], man_r};
            s4_exc = {2'b00, inx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            exception <= '0;
        end else if (!stall) begin
            v0  <= in_valid && in_ready;
            a0  <= in1;
            b0  <= {in2[W-1] ^ op_sub, in2[W-2:0]};
            rm0 <= (rounding_mode > RM_RMM) ? RM_RNE : rounding_mode;

            v1     <= v0;
            rm1    <= rm0;
            spec1  <= s1_spec;
            sres1  <= s1_sres;
            sinv1  <= s1_sinv;
            sign1  <= s1_sign;
            sub1   <= s1_sub;
            zsign1 <= s1_zsign;
            exp1   <= e_big;
            fb1    <= f_big;
            fs1    <= f_aln;

            v2     <= v1;
            rm2    <= rm1;
            spec2  <= spec1;
            sres2  <= sres1;
            sinv2  <= sinv1;
            sign2  <= sign1;
            zsign2 <= zsign1;
            exp2   <= exp1;
            sum2   <= s2_sum;

            v3     <= v2;
            rm3    <= rm2;
            spec3  <= spec2;
            sres3  <= sres2;
            sinv3  <= sinv2;
            sign3  <= sign2;
            zsign3 <= zsign2;
            zero3  <= s3_zero;
            uf3    <= s3_uf;
            exp3   <= s3_exp;
            mn3    <= s3_mn;

            out_valid <= v3;
            out       <= s4_res;
            exception <= s4_exc;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision vectors, stall/reset streams,
// and one half-precision instance.
module tb_fp_addsub_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] in1, in2, out;
    logic [2:0]  rounding_mode, exception;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_in1, h_in2, h_out;
    logic [2:0]  h_exc;

    int checks = 0;
    int failures = 0;

    logic [31:0] vals [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                               32'h41100000, 32'h41200000};

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op_sub(op_sub), .rounding_mode(rounding_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .exception(exception)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in1(h_in1), .in2(h_in2), .op_sub(1'b0), .rounding_mode(3'b000),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out(h_out), .exception(h_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; checks acceptance, latency, result, flags, single pulse.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [2:0] rm,
                          input logic [31:0] eo, input logic [2:0] ee);
        int cnt;
        in1 = a; in2 = b; op_sub = sub; rounding_mode = rm;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_lat"}, cnt, 4);
        check({tag, "_out"}, out, eo);
        check({tag, "_exc"}, exception, ee);
        @(posedge clk); #1;
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    task automatic stream_test();
        int sent, got, extra;
        logic prev_stall;
        logic [31:0] prev_out;
        sent = 0; got = 0; extra = 0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            in_valid  = (sent < 8);
            in1 = vals[sent % 10]; in2 = 32'h3F800000; op_sub = 1'b0; rounding_mode = 3'd0;
            #1;
            if (prev_stall) begin
                check("stall_hold", out, prev_out);
                check("stall_vld", out_valid, 1);
            end
            if (out_valid && !out_ready) check("stall_rdy", in_ready, 0);
            if (out_valid && out_ready) begin
                check($sformatf("stream_%0d", got), out, vals[(got + 1) % 10]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("stream_count", got, 8);
        check("stream_extra", extra, 0);
    endtask

    task automatic reset_test();
        int seen;
        out_ready = 1'b1; in2 = 32'h3F800000; op_sub = 1'b0; rounding_mode = 3'd0;
        for (int i = 0; i < 3; i++) begin
            in1 = vals[i]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("rst_rdy", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ovld", out_valid, 0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_drop", seen, 0);
        run_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 3'b000);
    endtask

    task automatic half_test();
        int cnt;
        h_in1 = 16'h3C00; h_in2 = 16'h3C00; h_in_valid = 1'b1;
        #1 check("h_rdy", h_in_ready, 1);
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        cnt = 0;
        while (!h_out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("h_lat", cnt, 4);
        check("h_out", h_out, 16'h4000);
        check("h_exc", h_exc, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0;
        op_sub = 1'b0; rounding_mode = 3'd0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_in1 = '0; h_in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_exception", exception, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 3'b000);
        run_op("ulp_rne",       32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 3'b001);
        run_op("ulp_rup",       32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 3'b001);
        run_op("ulp_rtz",       32'h3F800000, 32'h33800000, 1'b0, 3'd1, 32'h3F800000, 3'b001);
        run_op("ulp_rmm",       32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 3'b001);
        run_op("ulp_rm5",       32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 3'b001);
        run_op("ovf_rne",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 3'b011);
        run_op("ovf_rtz",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 3'b011);
        run_op("ovf_rdn_pos",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 32'h7F7FFFFF, 3'b011);
        run_op("ovf_rup_neg",   32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 32'hFF7FFFFF, 3'b011);
        run_op("ovf_rdn_neg",   32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd2, 32'hFF800000, 3'b011);
        run_op("cancel_rne",    32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 3'b000);
        run_op("cancel_rdn",    32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 3'b000);
        run_op("negzero_sum",   32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 3'b000);
        run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7FC00000, 3'b100);
        run_op("snan_in",       32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 3'b100);
        run_op("qnan_in",       32'h3F800000, 32'h7FC00001, 1'b0, 3'd0, 32'h7FC00000, 3'b000);
        run_op("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 32'h7F800000, 3'b000);
        run_op("one_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 3'd0, 32'hFF800000, 3'b000);
        run_op("sub_normalise", 32'h3FC00000, 32'h40400000, 1'b1, 3'd0, 32'hBFC00000, 3'b000);
        run_op("denorm_flush",  32'h00000001, 32'h3F800000, 1'b0, 3'd0, 32'h3F800000, 3'b000);
        run_op("underflow",     32'h00800001, 32'h00800000, 1'b1, 3'd0, 32'h00000000, 3'b001);
        run_op("far_rne",       32'h3F800000, 32'h00800000, 1'b0, 3'd0, 32'h3F800000, 3'b001);
        run_op("far_rup",       32'h3F800000, 32'h00800000, 1'b0, 3'd3, 32'h3F800001, 3'b001);

        stream_test();
        reset_test();
        half_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
